// File: rtl/soc_pkg.sv
// ---------------------------------------------------------------------------
// soc_pkg
// Shared SoC definitions used by the boot-ROM bus slave and its decoder.
//   prom_state_e   : bus-slave FSM states (IDLE, READ, RESP)
//   BOOT_ROM_BASE  : byte address of boot-ROM word 0
//   BOOT_ROM_AW    : boot-ROM word-address width (1024 words)
// ---------------------------------------------------------------------------
package soc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } prom_state_e;

    localparam logic [31:0] BOOT_ROM_BASE = 32'h0000_0000;
    localparam int          BOOT_ROM_AW   = 10;

endpackage : soc_pkg

// File: rtl/prom_addr_decode.sv
// ---------------------------------------------------------------------------
// prom_addr_decode
// Combinational address decoder for a word-organised memory window.
// The window starts at BASE_ADDR and spans 4 << AW bytes. Only aligned
// reads inside the window hit; everything else is an error.
//   addr_i      : byte address of the request
//   we_i        : 1 = write (never a hit)
//   hit_o       : aligned read inside the window
//   err_o       : inverse of hit_o
//   word_addr_o : word index inside the window
// ---------------------------------------------------------------------------
module prom_addr_decode
    import soc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BOOT_ROM_BASE,
    parameter int          AW        = BOOT_ROM_AW
) (
    input  logic [31:0]   addr_i,
    input  logic          we_i,
    output logic          hit_o,
    output logic          err_o,
    output logic [AW-1:0] word_addr_o
);

    // Window size in bytes, one bit wider so that large AW cannot overflow.
    localparam logic [32:0] WIN_BYTES = 33'd4 << AW;

    logic [31:0] off;
    logic        in_win;
    logic        aligned;

    // Plain 32-bit subtraction: addresses below the base wrap to a huge
    // offset and fall outside the window, which also covers a base near 2^32.
    assign off         = addr_i - BASE_ADDR;
    assign in_win      = ({1'b0, off} < WIN_BYTES);
    assign aligned     = (addr_i[1:0] == 2'b00);
    assign hit_o       = in_win & aligned & ~we_i;
    assign err_o       = ~hit_o;
    assign word_addr_o = off[AW+1:2];

endmodule : prom_addr_decode

// File: rtl/prom_bus_slave.sv
// ---------------------------------------------------------------------------
// prom_bus_slave
// Valid/ready bus-slave front end for a synchronous-read boot pROM with
// one cycle of data latency. The pROM itself lives in the parent.
//   clk, reset_n           : clock, synchronous active-low reset
//   req_valid/ready/addr/we: read request channel (writes answered with error)
//   resp_valid/ready       : response channel
//   resp_rdata, resp_err   : held response data and error flag
//   rom_ad, rom_ce         : pROM word address and clock enable
//   rom_oce, rom_reset     : pROM output enable (tied 1), pROM reset
//   rom_dout               : pROM read data
// Build option PROM_BACK2BACK_EN: accept the next request in the cycle the
// current response handshakes (adds a resp_ready -> req_ready/rom_ce path).
// ---------------------------------------------------------------------------
module prom_bus_slave
    import soc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BOOT_ROM_BASE,
    parameter int          ROM_AW    = BOOT_ROM_AW,
    parameter int          DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              req_we,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ROM_AW-1:0] rom_ad,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic              rom_reset,
    input  logic [DATA_W-1:0] rom_dout
);

    prom_state_e       state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q,   err_d;

    logic              dec_hit;
    logic              dec_err;
    logic              accept;

    prom_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .AW        (ROM_AW)
    ) u_decode (
        .addr_i      (req_addr),
        .we_i        (req_we),
        .hit_o       (dec_hit),
        .err_o       (dec_err),
        .word_addr_o (rom_ad)
    );

    // The pROM samples rom_ad on the same edge that accepts the request.
    assign accept     = req_valid & req_ready;
    assign rom_ce     = accept & dec_hit;
    assign rom_oce    = 1'b1;
    assign rom_reset  = ~reset_n;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Ready is forced low while reset is held so nothing is accepted or
    // enabled on the pROM until the slave is out of reset.
    always_comb begin
        req_ready = 1'b0;
        case (state_q)
            IDLE:    req_ready = reset_n;
`ifdef PROM_BACK2BACK_EN
            RESP:    req_ready = reset_n & resp_ready;
`endif
            default: req_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec_hit) begin
                        state_d = READ;
                    end else begin
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = dec_err;
                    end
                end
            end
            READ: begin
                // pROM output is valid in the cycle after the enable edge.
                state_d = RESP;
                rdata_d = rom_dout;
                err_d   = 1'b0;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
`ifdef PROM_BACK2BACK_EN
                    if (accept) begin
                        if (dec_hit) begin
                            state_d = READ;
                        end else begin
                            state_d = RESP;
                            rdata_d = '0;
                            err_d   = dec_err;
                        end
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset drops any in-flight read or held response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule : prom_bus_slave

// File: tb/tb_prom_bus_slave.sv
// ---------------------------------------------------------------------------
// tb_prom_bus_slave
// Directed bench for prom_bus_slave with a behavioural 1024x32 pROM model.
// ---------------------------------------------------------------------------
module tb_prom_bus_slave;

    localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef PROM_BACK2BACK_EN
    localparam int EXP_GAP = 2;
`else
    localparam int EXP_GAP = 3;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  rom_ad;
    logic        rom_ce;
    logic        rom_oce;
    logic        rom_reset;
    logic [31:0] rom_dout = 32'h0;

    logic [31:0] rom_mem [1024];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int ce_cnt   = 0;
    int hs_cnt   = 0;
    int acc_n    = 0;
    int rsp_n    = 0;
    int acc_cyc [8];
    logic [31:0] rsp_data [8];
    logic log_en = 1'b0;

    always #5 clk = ~clk;

    prom_bus_slave dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .rom_ad     (rom_ad),
        .rom_ce     (rom_ce),
        .rom_oce    (rom_oce),
        .rom_reset  (rom_reset),
        .rom_dout   (rom_dout)
    );

    // pROM model plus event counters and logs.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rom_ce) begin
            rom_dout <= rom_mem[rom_ad];
            ce_cnt   <= ce_cnt + 1;
        end
        if (resp_valid && resp_ready) begin
            hs_cnt <= hs_cnt + 1;
            if (log_en && rsp_n < 8) begin
                rsp_data[rsp_n] <= resp_rdata;
                rsp_n           <= rsp_n + 1;
            end
        end
        if (log_en && req_valid && req_ready && acc_n < 8) begin
            acc_cyc[acc_n] <= cyc;
            acc_n          <= acc_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic err_txn(input string tag, input logic [31:0] a, input logic w);
        int ce0;
        ce0 = ce_cnt;
        tick();
        req_valid = 1'b1; req_addr = a; req_we = w; resp_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, 32'(req_ready), 32'd1);
        check({tag, "_ce"},  32'(rom_ce),    32'd0);
        tick();
        req_valid = 1'b0; req_we = 1'b0;
        #1;
        check({tag, "_vld"},   32'(resp_valid), 32'd1);
        check({tag, "_err"},   32'(resp_err),   32'd1);
        check({tag, "_rdata"}, resp_rdata,      32'h0);
        tick();
        #1;
        check({tag, "_done"},  32'(resp_valid), 32'd0);
        check({tag, "_ce_n"},  32'(ce_cnt - ce0), 32'd0);
    endtask

    initial begin
        int hs0;
        int ce0;
        int idx;
        logic [31:0] exp_b2b [4];

        for (int i = 0; i < 1024; i++) rom_mem[i] = {16'hA5A5, 16'(i)};
        rom_mem[0]     = 32'h0000_02B7;
        rom_mem[1]     = 32'h1111_1111;
        rom_mem[2]     = 32'hDEAD_BEEF;
        rom_mem[3]     = 32'h3333_3333;
        rom_mem[1023]  = 32'hCAFE_F00D;
        exp_b2b[0] = 32'h0000_02B7; exp_b2b[1] = 32'h1111_1111;
        exp_b2b[2] = 32'hDEAD_BEEF; exp_b2b[3] = 32'h3333_3333;

        // Reset state, with a valid hit request presented to prove gating.
        reset_n = 1'b0; req_valid = 1'b1; req_addr = BASE; req_we = 1'b0; resp_ready = 1'b0;
        tick(); tick();
        #1;
        check("rst_rdy",   32'(req_ready),  32'd0);
        check("rst_vld",   32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata,      32'h0);
        check("rst_err",   32'(resp_err),   32'd0);
        check("rst_ce",    32'(rom_ce),     32'd0);
        check("rst_romrst",32'(rom_reset),  32'd1);
        check("rst_oce",   32'(rom_oce),    32'd1);
        req_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        #1;
        check("idle_rdy",    32'(req_ready), 32'd1);
        check("idle_romrst", 32'(rom_reset), 32'd0);

        // Read hit of word 0.
        tick();
        req_valid = 1'b1; req_addr = BASE; resp_ready = 1'b1;
        #1;
        check("hit_rdy", 32'(req_ready), 32'd1);
        check("hit_ce",  32'(rom_ce),    32'd1);
        check("hit_ad",  32'(rom_ad),    32'd0);
        tick();
        req_valid = 1'b0;
        #1;
        check("hit_read_vld", 32'(resp_valid), 32'd0);
        check("hit_read_rdy", 32'(req_ready),  32'd0);
        tick();
        #1;
        check("hit_vld",   32'(resp_valid), 32'd1);
        check("hit_rdata", resp_rdata,      32'h0000_02B7);
        check("hit_err",   32'(resp_err),   32'd0);
        tick();
        #1;
        check("hit_done_vld", 32'(resp_valid), 32'd0);
        check("hit_done_rdy", 32'(req_ready),  32'd1);

        // Back-pressure on a read of word 2.
        hs0 = hs_cnt; ce0 = ce_cnt;
        tick();
        req_valid = 1'b1; req_addr = BASE + 32'h8; resp_ready = 1'b0;
        #1;
        check("bp_ce", 32'(rom_ce), 32'd1);
        check("bp_ad", 32'(rom_ad), 32'd2);
        tick();
        req_addr = BASE + 32'hC;
        #1;
        check("bp_read_rdy", 32'(req_ready), 32'd0);
        check("bp_read_ce",  32'(rom_ce),    32'd0);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_stall_vld",   32'(resp_valid), 32'd1);
            check("bp_stall_rdata", resp_rdata,      32'hDEAD_BEEF);
            check("bp_stall_rdy",   32'(req_ready),  32'd0);
            check("bp_stall_ce",    32'(rom_ce),     32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        #1;
        check("bp_done_vld", 32'(resp_valid),     32'd0);
        check("bp_hs_cnt",   32'(hs_cnt - hs0),   32'd1);
        check("bp_ce_cnt",   32'(ce_cnt - ce0),   32'd1);

        // Error responses.
        err_txn("err_write", BASE + 32'h4,    1'b1);
        err_txn("err_misal", BASE + 32'h2,    1'b0);
        err_txn("err_oow",   BASE + 32'h1000, 1'b0);

        // Last word of the window.
        tick();
        req_valid = 1'b1; req_addr = BASE + 32'hFFC; resp_ready = 1'b1;
        #1;
        check("last_ce", 32'(rom_ce), 32'd1);
        check("last_ad", 32'(rom_ad), 32'h3FF);
        tick();
        req_valid = 1'b0;
        tick();
        #1;
        check("last_vld",   32'(resp_valid), 32'd1);
        check("last_rdata", resp_rdata,      32'hCAFE_F00D);
        check("last_err",   32'(resp_err),   32'd0);
        tick();

        // Reset during READ.
        hs0 = hs_cnt;
        req_valid = 1'b1; req_addr = BASE + 32'h4; resp_ready = 1'b1;
        tick();
        req_valid = 1'b0; reset_n = 1'b0;
        tick();
        #1;
        check("rstrd_vld",    32'(resp_valid), 32'd0);
        check("rstrd_romrst", 32'(rom_reset),  32'd1);
        check("rstrd_rdy",    32'(req_ready),  32'd0);
        reset_n = 1'b1;
        tick();
        #1;
        check("rstrd_rel_rdy", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("rstrd_stale_vld", 32'(resp_valid), 32'd0);
            tick();
            #1;
        end
        check("rstrd_hs", 32'(hs_cnt - hs0), 32'd0);

        // Reset during RESP.
        req_valid = 1'b1; req_addr = BASE + 32'h4; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        #1;
        check("rstrs_pre_vld",   32'(resp_valid), 32'd1);
        check("rstrs_pre_rdata", resp_rdata,      32'h1111_1111);
        reset_n = 1'b0;
        tick();
        #1;
        check("rstrs_vld",    32'(resp_valid), 32'd0);
        check("rstrs_rdata",  resp_rdata,      32'h0);
        check("rstrs_romrst", 32'(rom_reset),  32'd1);
        reset_n = 1'b1; resp_ready = 1'b1;
        hs0 = hs_cnt;
        tick();
        #1;
        check("rstrs_rel_rdy", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("rstrs_stale_vld", 32'(resp_valid), 32'd0);
            tick();
            #1;
        end
        check("rstrs_hs", 32'(hs_cnt - hs0), 32'd0);

        // Consecutive hits, words 0..3, bounded to 40 cycles.
        log_en = 1'b1;
        idx = 0;
        for (int c = 0; c < 40 && rsp_n < 4; c++) begin
            tick();
            req_valid  = (idx < 4);
            req_addr   = BASE + 32'(idx * 4);
            resp_ready = 1'b1;
            #1;
            if (req_valid && req_ready) idx++;
        end
        req_valid = 1'b0;
        tick();
        log_en = 1'b0;
        check("b2b_acc_n", 32'(acc_n), 32'd4);
        check("b2b_rsp_n", 32'(rsp_n), 32'd4);
        for (int i = 0; i < 3; i++)
            check("b2b_gap", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'(EXP_GAP));
        for (int i = 0; i < 4; i++)
            check("b2b_rdata", rsp_data[i], exp_b2b[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_prom_bus_slave
